// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the multicycle ARM controller
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // ALU opcodes reuse the ARM data-processing cmd field encoding
    typedef enum logic [3:0] {
        ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3,
        ALU_ADD = 4'h4, ALU_ADC = 4'h5, ALU_SBC = 4'h6, ALU_RSC = 4'h7,
        ALU_TST = 4'h8, ALU_TEQ = 4'h9, ALU_CMP = 4'hA, ALU_CMN = 4'hB,
        ALU_ORR = 4'hC, ALU_MOV = 4'hD, ALU_BIC = 4'hE, ALU_MVN = 4'hF
    } alu_op_t;

    typedef enum logic [3:0] {
        C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
        C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
    } cond_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        alu_op_t    alu_control;
    } ctrl_t;

    function automatic logic is_arith(alu_op_t op);
        return op inside {ALU_ADD, ALU_SUB, ALU_RSB, ALU_ADC, ALU_SBC, ALU_CMP, ALU_CMN};
    endfunction

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - condition-field evaluation and NZ/CV flag-update enables
module cond_unit
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    input  logic [1:0] op,
    input  logic       s,
    input  logic [3:0] cmd,
    output logic       cond_ex,
    output logic       nz_en,
    output logic       cv_en
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond_t'(cond))
            C_EQ:    cond_ex = z;
            C_NE:    cond_ex = !z;
            C_CS:    cond_ex = c;
            C_CC:    cond_ex = !c;
            C_MI:    cond_ex = n;
            C_PL:    cond_ex = !n;
            C_VS:    cond_ex = v;
            C_VC:    cond_ex = !v;
            C_HI:    cond_ex = c && !z;
            C_LS:    cond_ex = !c || z;
            C_GE:    cond_ex = (n == v);
            C_LT:    cond_ex = (n != v);
            C_GT:    cond_ex = !z && (n == v);
            C_LE:    cond_ex = z || (n != v);
            C_AL:    cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign nz_en = s && cond_ex && (op == OP_DP);
    assign cv_en = nz_en && is_arith(alu_op_t'(cmd));

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM control FSM with NZCV register and store byte enables
module mc_controller
    import ctrl_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter bit         HALF_EN  = 1'b1,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Instr,
    input  logic [3:0]        ALUFlags,
    input  logic [1:0]        Adr_lo,
    input  logic              MemReady,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              IRWrite,
    output logic              MemWrite,
    output logic              RegWrite,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [3:0]        ALUControl,
    output logic [XLEN/8-1:0] be,
    output logic [3:0]        Flags,
    output logic [3:0]        state_o
);

    localparam int BE_W = XLEN / 8;

    state_t     state, next;
    ctrl_t      ctl;
    logic [3:0] flags;
    logic       cond_ex, nz_en, cv_en;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       i_bit, s_bit, b_bit, rd15, is_half, is_mem, is_test, half_bad, in_exec;
    logic       unused_bits;

    assign op       = Instr[27:26];
    assign cmd      = Instr[24:21];
    assign i_bit    = Instr[25];
    assign s_bit    = Instr[20];
    assign b_bit    = Instr[22];
    assign rd15     = (Instr[15:12] == 4'hF);
    assign is_half  = HALF_EN && (op == OP_DP) && (Instr[7:4] == 4'b1011);
    assign is_mem   = (op == OP_MEM) || is_half;
    assign is_test  = (cmd[3:2] == 2'b10);
    assign half_bad = is_half && Adr_lo[0];
    assign in_exec  = (state == S_EXECR) || (state == S_EXECI);
    assign unused_bits = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

    cond_unit u_cond (
        .cond    (Instr[31:28]),
        .flags   (flags),
        .op      (op),
        .s       (s_bit),
        .cmd     (cmd),
        .cond_ex (cond_ex),
        .nz_en   (nz_en),
        .cv_en   (cv_en)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= next;
    end

    // EXEC always advances to ALUWB, so sampling in EXEC is the EXEC->ALUWB edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= FLAG_RST;
        end else if (in_exec) begin
            if (nz_en) flags[3:2] <= ALUFlags[3:2];
            if (cv_en) flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_comb begin
        next = state;
        ctl  = '0;
        if (state != S_FETCH) begin
            ctl.imm_src = (op == OP_BR) ? 2'b10 : (is_mem ? 2'b01 : 2'b00);
            ctl.reg_src = {is_mem, op == OP_BR};
        end
        case (state)
            S_FETCH: begin
                ctl.alu_src_a   = 2'b01;
                ctl.alu_src_b   = 2'b10;
                ctl.result_src  = 2'b10;
                ctl.alu_control = ALU_ADD;
                if (MemReady) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    next         = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.alu_src_a   = 2'b01;
                ctl.alu_src_b   = 2'b10;
                ctl.result_src  = 2'b10;
                ctl.alu_control = ALU_ADD;
                if (!cond_ex)          next = S_FETCH;
                else if (is_mem)       next = S_MEMADR;
                else if (op == OP_BR)  next = S_BRANCH;
                else if (i_bit)        next = S_EXECI;
                else                   next = S_EXECR;
            end
            S_MEMADR: begin
                ctl.alu_src_b   = 2'b01;
                ctl.alu_control = Instr[23] ? ALU_ADD : ALU_SUB;
                next            = Instr[20] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctl.adr_src = 1'b1;
                if (MemReady) next = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.result_src = 2'b01;
                ctl.reg_write  = !rd15;
                ctl.pc_write   = rd15;
                next           = S_FETCH;
            end
            S_MEMWR: begin
                ctl.adr_src   = 1'b1;
                ctl.mem_write = !half_bad;
                if (MemReady) next = S_FETCH;
            end
            S_EXECR: begin
                ctl.alu_control = alu_op_t'(cmd);
                next            = S_ALUWB;
            end
            S_EXECI: begin
                ctl.alu_src_b   = 2'b01;
                ctl.alu_control = alu_op_t'(cmd);
                next            = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.reg_write = !is_test && !rd15;
                ctl.pc_write  = !is_test && rd15;
                next          = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a   = 2'b10;
                ctl.alu_src_b   = 2'b01;
                ctl.result_src  = 2'b10;
                ctl.alu_control = ALU_ADD;
                ctl.pc_write    = 1'b1;
                next            = S_FETCH;
            end
            default: next = S_FETCH;
        endcase
        // Reset forces every strobe and select low without waiting for a clock
        if (!reset) ctl = '0;
    end

    always_comb begin
        be = '0;
        if (state == S_MEMWR) begin
            if (is_half)    be = Adr_lo[0] ? '0 : (BE_W'(2'b11) << {Adr_lo[1], 1'b0});
            else if (b_bit) be = BE_W'(1) << Adr_lo;
            else            be = '1;
        end
    end

    assign PCWrite    = ctl.pc_write;
    assign AdrSrc     = ctl.adr_src;
    assign IRWrite    = ctl.ir_write;
    assign MemWrite   = ctl.mem_write;
    assign RegWrite   = ctl.reg_write;
    assign ALUSrcA    = ctl.alu_src_a;
    assign ALUSrcB    = ctl.alu_src_b;
    assign ResultSrc  = ctl.result_src;
    assign ImmSrc     = ctl.imm_src;
    assign RegSrc     = ctl.reg_src;
    assign ALUControl = ctl.alu_control;
    assign Flags      = flags;
    assign state_o    = state;

endmodule
